// File: rtl/ysyx_22040759_icache_axi_rd.sv
// rtl/ysyx_22040759_icache_axi_rd.sv - icache miss refill engine: one single-beat AXI read per miss
module ysyx_22040759_icache_axi_rd #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'h0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            icache_ram_ren,
    input  logic [63:0]     icache_ram_raddr,
    output logic [63:0]     ram_icache_rdata,
    output logic            icache_data_valid,
    output logic            rd_err,

    output logic            axi_ar_valid_o,
    input  logic            axi_ar_ready_i,
    output logic [63:0]     axi_ar_addr_o,
    output logic [ID_W-1:0] axi_ar_id_o,
    output logic [7:0]      axi_ar_len_o,
    output logic [2:0]      axi_ar_size_o,
    output logic [1:0]      axi_ar_burst_o,
    output logic [2:0]      axi_ar_prot_o,

    input  logic            axi_r_valid_i,
    output logic            axi_r_ready_o,
    input  logic [63:0]     axi_r_data_i,
    input  logic [1:0]      axi_r_resp_i,
    input  logic            axi_r_last_i,
    input  logic [ID_W-1:0] axi_r_id_i,

    output logic [31:0]     miss_cnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [31:0] cnt_q,   cnt_d;

    logic        beat_ours;

    // A beat belongs to us only when it carries our ID; foreign beats are drained and dropped
    assign beat_ours = axi_r_valid_i && (axi_r_id_i == AXI_ID);

    // Next-state and datapath update for the refill sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (icache_ram_ren) begin
                    addr_d  = {icache_ram_raddr[63:3], 3'b000};
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (axi_ar_ready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_ours) begin
                    rdata_d = axi_r_data_i;
                    if (axi_r_resp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (axi_r_last_i) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = cnt_q + 32'd1;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight read outright
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign axi_ar_valid_o    = (state_q == ADDR);
    assign axi_ar_addr_o     = addr_q;
    assign axi_ar_id_o       = AXI_ID;
    assign axi_ar_len_o      = 8'd0;
    assign axi_ar_size_o     = 3'b011;
    assign axi_ar_burst_o    = 2'b01;
    assign axi_ar_prot_o     = 3'b100;
    assign axi_r_ready_o     = (state_q == DATA);

    assign icache_data_valid = (state_q == RESP);
    assign rd_err            = (state_q == RESP) && err_q;
    assign ram_icache_rdata  = rdata_q;
    assign miss_cnt_o        = cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_icache_axi_rd.sv
// tb/tb_ysyx_22040759_icache_axi_rd.sv - self-checking bench for the icache AXI refill engine
module tb_ysyx_22040759_icache_axi_rd;

    localparam int         ID_W   = 4;
    localparam logic [3:0] AXI_ID = 4'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_ram_ren;
    logic [63:0] icache_ram_raddr;
    logic [63:0] ram_icache_rdata;
    logic        icache_data_valid;
    logic        rd_err;
    logic        axi_ar_valid_o;
    logic        axi_ar_ready_i;
    logic [63:0] axi_ar_addr_o;
    logic [3:0]  axi_ar_id_o;
    logic [7:0]  axi_ar_len_o;
    logic [2:0]  axi_ar_size_o;
    logic [1:0]  axi_ar_burst_o;
    logic [2:0]  axi_ar_prot_o;
    logic        axi_r_valid_i;
    logic        axi_r_ready_o;
    logic [63:0] axi_r_data_i;
    logic [1:0]  axi_r_resp_i;
    logic        axi_r_last_i;
    logic [3:0]  axi_r_id_i;
    logic [31:0] miss_cnt_o;

    ysyx_22040759_icache_axi_rd #(.ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
        .clk(clk), .rst(rst),
        .icache_ram_ren(icache_ram_ren), .icache_ram_raddr(icache_ram_raddr),
        .ram_icache_rdata(ram_icache_rdata), .icache_data_valid(icache_data_valid), .rd_err(rd_err),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_prot_o(axi_ar_prot_o),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_data_i(axi_r_data_i),
        .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        int          ar_wait;
        logic [63:0] data;
        logic [1:0]  resp;
        bit          bad_first;
        logic [63:0] exp_araddr;
        logic        exp_err;
    } vec_t;

    beat_t       beats[$];
    vec_t        tbl[5];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt;
    logic [63:0] mdl_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drives one refill as icache + AXI slave; beats[] supplies the R channel traffic
    task automatic run_txn(input logic [63:0] addr, input int ar_wait, input bit chk_lat,
                           output logic [63:0] got_araddr, output logic got_err);
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic        exp_err;
        int          start;
        int          n;
        exp_addr = {addr[63:3], 3'b000};
        exp_err  = 1'b0;
        exp_data = mdl_rdata;
        foreach (beats[i]) begin
            if (beats[i].id == AXI_ID) begin
                exp_data = beats[i].data;
                exp_err  = exp_err | (beats[i].resp != 2'b00);
            end
        end
        got_araddr = 64'hx;
        got_err    = 1'bx;
        start = cyc;
        icache_ram_ren   = 1'b1;
        icache_ram_raddr = addr;
        @(negedge clk);
        n = 0;
        while (!axi_ar_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arvalid_seen", 64'(axi_ar_valid_o), 64'd1);
        if (!axi_ar_valid_o) begin
            icache_ram_ren = 1'b0;
            return;
        end
        if (chk_lat) check("lat_arvalid", 64'(cyc - start), 64'd1);
        icache_ram_raddr = ~addr;
        for (int w = 0; w < ar_wait; w++) begin
            check("ar_addr_stable", axi_ar_addr_o, exp_addr);
            check("ar_valid_hold", 64'(axi_ar_valid_o), 64'd1);
            check("r_ready_in_addr", 64'(axi_r_ready_o), 64'd0);
            check("dv_in_addr", 64'(icache_data_valid), 64'd0);
            @(negedge clk);
        end
        got_araddr = axi_ar_addr_o;
        check("ar_addr", axi_ar_addr_o, exp_addr);
        check("ar_consts", {axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o, axi_ar_prot_o},
              {AXI_ID, 8'd0, 3'b011, 2'b01, 3'b100});
        axi_ar_ready_i = 1'b1;
        @(negedge clk);
        axi_ar_ready_i = 1'b0;
        check("ar_valid_after_hs", 64'(axi_ar_valid_o), 64'd0);
        check("r_ready_data", 64'(axi_r_ready_o), 64'd1);
        foreach (beats[i]) begin
            for (int g = 0; g < beats[i].gap; g++) begin
                @(negedge clk);
                check("gap_r_ready", 64'(axi_r_ready_o), 64'd1);
                check("gap_dv", 64'(icache_data_valid), 64'd0);
            end
            axi_r_valid_i = 1'b1;
            axi_r_data_i  = beats[i].data;
            axi_r_resp_i  = beats[i].resp;
            axi_r_id_i    = beats[i].id;
            axi_r_last_i  = beats[i].last;
            @(negedge clk);
            axi_r_valid_i = 1'b0;
            if (beats[i].id == AXI_ID) mdl_rdata = beats[i].data;
            check("rdata_track", ram_icache_rdata, mdl_rdata);
            if (i != beats.size() - 1) begin
                check("stay_data", 64'(axi_r_ready_o), 64'd1);
                check("no_dv_mid", 64'(icache_data_valid), 64'd0);
            end
        end
        check("data_valid", 64'(icache_data_valid), 64'd1);
        check("refill_data", ram_icache_rdata, exp_data);
        check("rd_err", 64'(rd_err), 64'(exp_err));
        check("r_ready_resp", 64'(axi_r_ready_o), 64'd0);
        got_err = rd_err;
        if (chk_lat) check("lat_dv", 64'(cyc - start), 64'd3);
        icache_ram_ren = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        check("dv_pulse", 64'(icache_data_valid), 64'd0);
        check("rd_err_clear", 64'(rd_err), 64'd0);
        check("idle_ar", 64'(axi_ar_valid_o), 64'd0);
        check("miss_cnt", 64'(miss_cnt_o), 64'(exp_cnt));
        check("rdata_hold", ram_icache_rdata, exp_data);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {63'd0, axi_ar_valid_o | axi_r_ready_o | icache_data_valid | rd_err}, 64'd0);
        check({tag, "_rdata"}, ram_icache_rdata, 64'd0);
        check({tag, "_araddr"}, axi_ar_addr_o, 64'd0);
        check({tag, "_cnt"}, 64'(miss_cnt_o), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] ga;
        logic        ge;
        int          nb;
        logic [3:0]  id;

        rst = 1'b1;
        icache_ram_ren = 1'b0;  icache_ram_raddr = 64'd0;
        axi_ar_ready_i = 1'b0;  axi_r_valid_i = 1'b0;  axi_r_data_i = 64'd0;
        axi_r_resp_i = 2'b00;   axi_r_last_i = 1'b0;   axi_r_id_i = 4'd0;
        exp_cnt = 32'd0;
        mdl_rdata = 64'd0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        tbl[0] = '{64'h0000_0000_8000_0004, 0, 64'h0000_0013_0000_0093, 2'b00, 1'b0, 64'h0000_0000_8000_0000, 1'b0};
        tbl[1] = '{64'h0000_0000_8000_1238, 5, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 64'h0000_0000_8000_1238, 1'b0};
        tbl[2] = '{64'h0000_0000_8000_00ff, 0, 64'hdead_beef_0bad_f00d, 2'b10, 1'b0, 64'h0000_0000_8000_00f8, 1'b1};
        tbl[3] = '{64'h0000_0000_8000_0100, 1, 64'hcafe_babe_1234_5678, 2'b00, 1'b0, 64'h0000_0000_8000_0100, 1'b0};
        tbl[4] = '{64'h0000_0000_8000_0207, 2, 64'h0123_4567_89ab_cdef, 2'b00, 1'b1, 64'h0000_0000_8000_0200, 1'b0};

        for (int t = 0; t < 5; t++) begin
            beats.delete();
            if (tbl[t].bad_first) beats.push_back('{~tbl[t].data, 2'b10, 4'h3, 1'b1, 0});
            beats.push_back('{tbl[t].data, tbl[t].resp, AXI_ID, 1'b1, 0});
            run_txn(tbl[t].addr, tbl[t].ar_wait, (t == 0), ga, ge);
            check($sformatf("tbl%0d_araddr", t), ga, tbl[t].exp_araddr);
            check($sformatf("tbl%0d_err", t), 64'(ge), 64'(tbl[t].exp_err));
        end

        for (int r = 0; r < 30; r++) begin
            beats.delete();
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                id = ($urandom_range(0, 2) == 0) ? AXI_ID : 4'($urandom_range(1, 15));
                beats.push_back('{{$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                                  id, (id != AXI_ID) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 2)});
            end
            beats.push_back('{{$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                              AXI_ID, 1'b1, $urandom_range(0, 2)});
            run_txn({$urandom, $urandom}, $urandom_range(0, 4), 1'b0, ga, ge);
        end

        // Reset while waiting for read data
        icache_ram_ren = 1'b1;
        icache_ram_raddr = 64'h0000_0000_8000_0abc;
        @(negedge clk);
        axi_ar_ready_i = 1'b1;
        @(negedge clk);
        axi_ar_ready_i = 1'b0;
        icache_ram_ren = 1'b0;
        check("rst_pre_data", 64'(axi_r_ready_o), 64'd1);
        rst = 1'b1;
        axi_r_valid_i = 1'b1; axi_r_data_i = 64'h5555_aaaa_5555_aaaa;
        axi_r_id_i = AXI_ID; axi_r_last_i = 1'b1; axi_r_resp_i = 2'b10;
        @(negedge clk);
        rst = 1'b0;
        axi_r_valid_i = 1'b0;
        check_all_zero("mid_rst");
        @(negedge clk);
        check_all_zero("post_rst_idle");
        exp_cnt = 32'd0;
        mdl_rdata = 64'd0;
        beats.delete();
        beats.push_back('{64'h0f0f_0f0f_f0f0_f0f0, 2'b00, AXI_ID, 1'b1, 0});
        run_txn(64'h0000_0000_8000_0040, 0, 1'b1, ga, ge);

        // Counter wrap: preload the count register, then one refill
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        check("cnt_preload", 64'(miss_cnt_o), 64'h0000_0000_FFFF_FFFF);
        beats.delete();
        beats.push_back('{64'h7777_8888_9999_aaaa, 2'b00, AXI_ID, 1'b1, 1});
        run_txn(64'h0000_0000_8000_0008, 1, 1'b0, ga, ge);
        check("cnt_wrap", 64'(miss_cnt_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_icache_axi_rd.md
YSYX_22040759_ICACHE_AXI_RD -- requirements
Module: ysyx_22040759_icache_axi_rd

Interface
REQ-001 Parameter: AXI_ID, default 4'h0; fixed ARID driven on every request.
REQ-002 Parameter: ID_W, default 4; width of the ARID and RID fields.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset; synchronous and active-high.
REQ-005 Port: icache_ram_ren  in  1  miss request from the icache; level, held until serviced.
REQ-006 Port: icache_ram_raddr  in  64  miss address from the icache.
REQ-007 Port: ram_icache_rdata  out  64  refill data to the icache.
REQ-008 Port: icache_data_valid  out  1  refill-valid pulse to the icache.
REQ-009 Port: rd_err  out  1  qualifies icache_data_valid; RRESP was non-OKAY.
REQ-010 Port: axi_ar_valid_o  out  1  AXI read-address valid.
REQ-011 Port: axi_ar_ready_i  in  1  AXI read-address ready.
REQ-012 Port: axi_ar_addr_o  out  64  AXI read address.
REQ-013 Port: axi_ar_id_o  out  ID_W  AXI ARID.
REQ-014 Port: axi_ar_len_o  out  8  AXI ARLEN.
REQ-015 Port: axi_ar_size_o  out  3  AXI ARSIZE.
REQ-016 Port: axi_ar_burst_o  out  2  AXI ARBURST.
REQ-017 Port: axi_ar_prot_o  out  3  AXI ARPROT.
REQ-018 Port: axi_r_valid_i  in  1  AXI read-data valid.
REQ-019 Port: axi_r_ready_o  out  1  AXI read-data ready.
REQ-020 Port: axi_r_data_i  in  64  AXI read data.
REQ-021 Port: axi_r_resp_i  in  2  AXI read response.
REQ-022 Port: axi_r_last_i  in  1  AXI last beat.
REQ-023 Port: axi_r_id_i  in  ID_W  AXI RID.
REQ-024 Port: miss_cnt_o  out  32  count of completed refills.

Function
REQ-025 FSM SHALL have four states: IDLE, ADDR, DATA, RESP.
REQ-026 IDLE: icache_ram_ren=1 -> latch {icache_ram_raddr[63:3],3'b000} into the address register, go to ADDR; otherwise stay in IDLE.
REQ-027 ADDR: axi_ar_valid_o=1 with a stable address; on axi_ar_ready_i=1 -> DATA; arvalid SHALL NOT drop before the handshake.
REQ-028 Constants on AR: ARLEN=0, ARSIZE=3'b011, ARBURST=2'b01, ARPROT=3'b100, ARID=AXI_ID.
REQ-029 DATA: axi_r_ready_o=1; r_ready SHALL be 0 in every other state.
REQ-030 DATA: a beat with r_valid=1 and RID==AXI_ID SHALL capture r_data into ram_icache_rdata; r_resp!=2'b00 SHALL set a sticky error flag.
REQ-031 DATA: the transaction completes on a captured beat with r_last=1 -> RESP.
REQ-032 DATA: a beat with r_last=0 SHALL be captured and the FSM SHALL stay in DATA; only the last captured data is delivered.
REQ-033 DATA: a beat with a mismatched RID SHALL be accepted and discarded, with no state change.
REQ-034 RESP: icache_data_valid=1 for exactly one cycle; rd_err = sticky error flag; miss_cnt_o increments by 1, wrapping at 32'hFFFFFFFF -> 0; next state IDLE; sticky error flag cleared.
REQ-035 icache_data_valid SHALL be 1 only in RESP.
REQ-036 ram_icache_rdata SHALL hold its value until the next captured beat.
REQ-037 icache_ram_ren SHALL be sampled only in IDLE; changes in other states are ignored.
REQ-038 The cycle after RESP is always IDLE, so the icache tag update lands before ren is re-sampled.
REQ-039 Minimum latency: ren sampled at cycle N, arvalid at N+1, arready at N+1 -> DATA at N+2, rvalid+rlast at N+2 -> data_valid at N+3.
REQ-040 No back-to-back AR; at most one outstanding transaction.

Reset
REQ-041 With rst=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-042 With rst=1 at a clock edge, axi_ar_valid_o, axi_r_ready_o, icache_data_valid and rd_err SHALL be 0.
REQ-043 With rst=1 at a clock edge, ram_icache_rdata, the address register and miss_cnt_o SHALL be 0, and the error flag SHALL be cleared.
REQ-044 Reset in any state SHALL abort immediately; an in-flight AXI transaction is abandoned, since reset is system-wide.

Verification
REQ-045 ren=1, addr=0x8000_0004, arready=1, rvalid/rlast=1 next cycle with data 0x0000_0013_0000_0093, resp=0 -> araddr=0x8000_0000, data_valid pulse at N+3 with that data, rd_err=0, miss_cnt=1.
REQ-046 arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles, r_ready=0, no data_valid.
REQ-047 resp=2'b10 on the last beat -> data_valid=1 with rd_err=1 for one cycle; the next clean transaction gives rd_err=0.
REQ-048 RID=4'h3 beat then RID=4'h0 last beat -> only the second beat's data delivered.
REQ-049 rst=1 asserted in DATA -> next cycle IDLE, all outputs 0; a later request completes normally.
REQ-050 Preload miss_cnt=32'hFFFFFFFF via a forced sequence, complete one refill -> miss_cnt_o=0.
